// File: rtl/fsic_io_serdes_pkg.sv
// Shared types and constants for the FSIC IO serializer (TX side).
package fsic_io_serdes_pkg;

  localparam int unsigned DEF_CLK_RATIO = 4;

  // PRBS7, x^7 + x^6 + 1: feedback taps on bits 6 and 5
  localparam logic [6:0] PRBS7_SEED = 7'h7F;
  localparam logic [6:0] PRBS7_TAPS = 7'h60;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2
  } tx_state_e;

  function automatic logic [6:0] prbs7_next(input logic [6:0] s);
    return {s[5:0], ^(s & PRBS7_TAPS)};
  endfunction

endpackage

// File: rtl/fsic_clkgate.sv
// Glitch-free clock gate: enable captured on the falling edge, ANDed with clk.
module fsic_clkgate (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic gclk
);

  logic en_q;

  // en_q only moves while clk is low, so the AND cannot chop a high phase
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) en_q <= 1'b0;
    else        en_q <= en;
  end

  assign gclk = clk & en_q;

endmodule

// File: rtl/fsic_io_serdes_tx.sv
// Parallel-to-serial TX lane, LSB first, with forwarded gated ioclk.
// Optional PRBS7 test pattern under macro FSIC_SERDES_TX_PRBS_EN (adds txprbs_en).
module fsic_io_serdes_tx
  import fsic_io_serdes_pkg::*;
#(
  parameter int pCLK_RATIO = DEF_CLK_RATIO
) (
  input  logic                  ioclk,
  input  logic                  axis_rst_n,
  input  logic                  txen,
  input  logic [pCLK_RATIO-1:0] txdata_in,
  input  logic                  txdata_in_valid,
`ifdef FSIC_SERDES_TX_PRBS_EN
  input  logic                  txprbs_en,
`endif
  output logic                  Serial_Data_out,
  output logic                  txclk_out,
  output logic                  tx_active
);

  localparam int PW = (pCLK_RATIO > 2) ? $clog2(pCLK_RATIO) : 1;

  logic [PW-1:0]         phase;
  logic                  load_edge;
  tx_state_e             state;
  logic [pCLK_RATIO-1:0] sr;
  logic                  sdo_q;
  logic                  ser_bit;

  assign load_edge = (phase == PW'(pCLK_RATIO - 1));

  // free-running; power-of-two ratio lets it wrap naturally
  always_ff @(posedge ioclk or negedge axis_rst_n) begin
    if (!axis_rst_n) phase <= '0;
    else             phase <= phase + PW'(1);
  end

`ifdef FSIC_SERDES_TX_PRBS_EN
  logic [6:0] lfsr;

  always_ff @(posedge ioclk or negedge axis_rst_n) begin
    if (!axis_rst_n)                        lfsr <= PRBS7_SEED;
    else if (state == ST_RUN && txprbs_en)  lfsr <= prbs7_next(lfsr);
    else                                    lfsr <= PRBS7_SEED;
  end

  assign ser_bit = txprbs_en ? lfsr[6] : sr[0];
`else
  assign ser_bit = sr[0];
`endif

  // sdo_q retimes the data so each bit lines up with one txclk_out pulse
  always_ff @(posedge ioclk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state <= ST_IDLE;
      sr    <= '0;
      sdo_q <= 1'b0;
    end else begin
      sdo_q <= (state == ST_RUN) ? ser_bit : 1'b0;
      if (!txen) begin
        state <= ST_IDLE;
        sr    <= '0;
      end else begin
        case (state)
          ST_IDLE: state <= ST_WAIT;
          ST_WAIT: if (load_edge && txdata_in_valid) begin
            state <= ST_RUN;
            sr    <= txdata_in;
          end
          ST_RUN: begin
            if (load_edge) sr <= txdata_in_valid ? txdata_in : '0;
            else           sr <= sr >> 1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign tx_active       = (state == ST_RUN);
  assign Serial_Data_out = sdo_q & tx_active;

  fsic_clkgate u_clkgate (
    .clk   (ioclk),
    .rst_n (axis_rst_n),
    .en    (tx_active),
    .gclk  (txclk_out)
  );

endmodule

// File: tb/tb_fsic_io_serdes_tx.sv
// Directed bench for fsic_io_serdes_tx (pCLK_RATIO = 4).
module tb_fsic_io_serdes_tx;

  logic       ioclk = 1'b0;
  logic       axis_rst_n;
  logic       txen;
  logic [3:0] txdata_in;
  logic       txdata_in_valid;
  logic       Serial_Data_out;
  logic       txclk_out;
  logic       tx_active;
`ifdef FSIC_SERDES_TX_PRBS_EN
  logic       txprbs_en;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int pulses = 0;

  always #5 ioclk = ~ioclk;
  always @(posedge txclk_out) pulses++;

  fsic_io_serdes_tx #(.pCLK_RATIO(4)) dut (
    .ioclk           (ioclk),
    .axis_rst_n      (axis_rst_n),
    .txen            (txen),
    .txdata_in       (txdata_in),
    .txdata_in_valid (txdata_in_valid),
`ifdef FSIC_SERDES_TX_PRBS_EN
    .txprbs_en       (txprbs_en),
`endif
    .Serial_Data_out (Serial_Data_out),
    .txclk_out       (txclk_out),
    .tx_active       (tx_active)
  );

  typedef struct {
    logic       txen;
    logic       valid;
    logic [3:0] data;
    logic       sdo;
    logic       clk;
    logic       act;
  } vec_t;

  vec_t tbl[26];

  task automatic tick();
    @(posedge ioclk);
    #1;
  endtask

  task automatic chk(input string nm, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic chk3(input string nm, input logic es, input logic ec, input logic ea);
    chk({nm, " sdo"}, Serial_Data_out, es);
    chk({nm, " txclk"}, txclk_out, ec);
    chk({nm, " active"}, tx_active, ea);
  endtask

  initial begin
    // per edge: inputs seen at that edge, outputs sampled just after it
    // words A,5,F,<invalid>,3,<invalid> loaded at edges 4,8,...,24
    tbl[0]  = '{1'b1, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 4'hA, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 4'h5, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 4'h5, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 4'h5, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 4'h5, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 4'hF, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 4'hF, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 4'hF, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 4'hF, 1'b0, 1'b1, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 4'h9, 1'b1, 1'b1, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 4'h9, 1'b1, 1'b1, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 4'h9, 1'b1, 1'b1, 1'b1};
    tbl[15] = '{1'b1, 1'b0, 4'h9, 1'b1, 1'b1, 1'b1};
    tbl[16] = '{1'b1, 1'b1, 4'h3, 1'b0, 1'b1, 1'b1};
    tbl[17] = '{1'b1, 1'b1, 4'h3, 1'b0, 1'b1, 1'b1};
    tbl[18] = '{1'b1, 1'b1, 4'h3, 1'b0, 1'b1, 1'b1};
    tbl[19] = '{1'b1, 1'b1, 4'h3, 1'b0, 1'b1, 1'b1};
    tbl[20] = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1};
    tbl[21] = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1};
    tbl[22] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1};
    tbl[23] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1};
    tbl[24] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0};
    tbl[25] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};

    axis_rst_n      = 1'b0;
    txen            = 1'b0;
    txdata_in       = 4'h0;
    txdata_in_valid = 1'b0;
`ifdef FSIC_SERDES_TX_PRBS_EN
    txprbs_en       = 1'b0;
`endif

    tick();
    tick();
    chk3("reset", 1'b0, 1'b0, 1'b0);

    @(negedge ioclk);
    axis_rst_n = 1'b1;
    pulses = 0;

    // continuous stream, including an invalid word in the middle
    for (int i = 0; i < 26; i++) begin
      txen            = tbl[i].txen;
      txdata_in_valid = tbl[i].valid;
      txdata_in       = tbl[i].data;
      tick();
      chk3($sformatf("vec[%0d]", i), tbl[i].sdo, tbl[i].clk, tbl[i].act);
    end
    // edges 5..25 each carry one uninterrupted pulse
    n_chk++;
    if (pulses != 21) begin
      n_fail++;
      $display("FAIL stream pulse count: got %0d expected 21", pulses);
    end

    // idle edges 27..29, then txen seen at a phase-1 edge (30)
    txen = 1'b0;
    repeat (3) tick();
    pulses = 0;
    txen = 1'b1; txdata_in = 4'hF; txdata_in_valid = 1'b1;
    tick(); chk3("late_en e30", 1'b0, 1'b0, 1'b0);
    tick(); chk3("late_en e31", 1'b0, 1'b0, 1'b0);
    tick(); chk3("late_en e32", 1'b0, 1'b0, 1'b1);
    chk("late_en no early pulse", pulses == 0, 1'b1);
    tick(); chk3("late_en bit0", 1'b1, 1'b1, 1'b1);
    tick(); chk3("late_en bit1", 1'b1, 1'b1, 1'b1);

    // truncate after bit 1
    txen = 1'b0;
    tick(); chk("trunc e35 sdo", Serial_Data_out, 1'b0);
    chk("trunc e35 active", tx_active, 1'b0);
    tick(); chk3("trunc e36", 1'b0, 1'b0, 1'b0);

    // restart: must wait for the next load edge (40)
    txen = 1'b1; txdata_in = 4'h5; txdata_in_valid = 1'b1;
    tick(); chk3("restart e37", 1'b0, 1'b0, 1'b0);
    tick(); chk3("restart e38", 1'b0, 1'b0, 1'b0);
    tick(); chk3("restart e39", 1'b0, 1'b0, 1'b0);
    tick(); chk3("restart e40", 1'b0, 1'b0, 1'b1);
    tick(); chk3("restart bit0", 1'b1, 1'b1, 1'b1);

    // async reset while txclk_out is high
    axis_rst_n = 1'b0;
    #1;
    chk3("async reset", 1'b0, 1'b0, 1'b0);
    tick();
    chk3("held reset", 1'b0, 1'b0, 1'b0);
    @(negedge ioclk);
    axis_rst_n = 1'b1;
    pulses = 0;
    tick(); chk3("post_rst e1", 1'b0, 1'b0, 1'b0);
    tick(); chk3("post_rst e2", 1'b0, 1'b0, 1'b0);
    tick(); chk3("post_rst e3", 1'b0, 1'b0, 1'b0);
    tick(); chk3("post_rst e4", 1'b0, 1'b0, 1'b1);
    chk("post_rst no early pulse", pulses == 0, 1'b1);
    tick(); chk3("post_rst bit0", 1'b1, 1'b1, 1'b1);
    tick(); chk3("post_rst bit1", 1'b0, 1'b1, 1'b1);

`ifdef FSIC_SERDES_TX_PRBS_EN
    begin
      logic [6:0] m;
      bit         up;
      txen = 1'b0;
      tick();
      txprbs_en = 1'b1;
      txen      = 1'b1;
      up        = 1'b0;
      for (int i = 0; i < 8 && !up; i++) begin
        tick();
        up = tx_active;
      end
      chk("prbs reached RUN", up, 1'b1);
      m = 7'h7F;
      // 134 bits: a full period plus the first 7 bits again
      for (int i = 0; i < 134; i++) begin
        tick();
        chk($sformatf("prbs bit %0d", i), Serial_Data_out, m[6]);
        chk($sformatf("prbs clk %0d", i), txclk_out, 1'b1);
        m = {m[5:0], m[6] ^ m[5]};
      end
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
